// File: rtl/i2c_otp_sequencer.sv
// i2c_otp_sequencer: arbitrates passcode-unlock and OTP requests into retried
// I2C register-write triples (DEV, REG, DATA) for the byte engine.
module i2c_otp_sequencer #(
  parameter logic [6:0] DEV_ADDR     = 7'h0A,
  parameter logic [7:0] REG_PASSCODE = 8'h05,
  parameter logic [7:0] REG_OTP      = 8'h04,
  parameter int         GAP_CYCLES   = 16,
  parameter int         MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        unlock_req,
  input  logic [47:0] passcode_in,
  input  logic        otp_req,
  input  logic [7:0]  otp_cmd,
  output logic        unlock_done,
  output logic        otp_done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        unlocked,
  output logic        busy,
  output logic        eng_valid,
  input  logic        eng_ready,
  output logic        eng_start,
  output logic        eng_stop,
  output logic [7:0]  eng_byte,
  input  logic        eng_done,
  input  logic        eng_nack
);
  localparam logic [2:0] S_IDLE = 3'd0, S_DEV = 3'd1, S_REG = 3'd2, S_DATA = 3'd3, S_WAIT = 3'd4, S_GAP = 3'd5;
  logic [2:0] state, ph, byte_idx, retry_cnt;
  logic [5:0][7:0] pc;
  logic [7:0] cmd, gap_cnt, pc_byte;
  logic is_unl, last_otp, retry, grant_unl;
  assign grant_unl = unlock_req && (!otp_req || last_otp);
  assign pc_byte = pc[3'd5 - byte_idx];
  // engine command decoded from registered state so it is stable while valid
  always_comb begin
    busy = state != S_IDLE;
    eng_valid = state == S_DEV || state == S_REG || state == S_DATA;
    eng_start = state == S_DEV;
    eng_stop = state == S_DATA;
    eng_byte = state == S_DEV ? {DEV_ADDR, 1'b0} :
               state == S_REG ? (is_unl ? REG_PASSCODE : REG_OTP) :
               state == S_DATA ? (is_unl ? pc_byte : cmd) : 8'h00;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ph <= S_IDLE;
      byte_idx <= '0;
      retry_cnt <= '0;
      pc <= '0;
      cmd <= '0;
      gap_cnt <= '0;
      is_unl <= 1'b0;
      last_otp <= 1'b1;
      retry <= 1'b0;
      unlock_done <= 1'b0;
      otp_done <= 1'b0;
      err <= 1'b0;
      err_code <= 2'b00;
      unlocked <= 1'b0;
    end else begin
      unlock_done <= 1'b0;
      otp_done <= 1'b0;
      err <= 1'b0;
      err_code <= 2'b00;
      case (state)
        S_IDLE: if (unlock_req || otp_req) begin
          is_unl <= grant_unl;
          last_otp <= !grant_unl;
          pc <= passcode_in;
          cmd <= otp_cmd;
          byte_idx <= '0;
          retry_cnt <= '0;
          retry <= 1'b0;
          gap_cnt <= '0;
          if (!grant_unl && !unlocked) begin
            err <= 1'b1;
            err_code <= 2'b10;
            state <= S_GAP;
          end else state <= S_DEV;
        end
        S_DEV, S_REG, S_DATA: if (eng_ready) begin
          ph <= state;
          state <= S_WAIT;
        end
        S_WAIT: if (eng_done) begin
          gap_cnt <= '0;
          if (eng_nack) begin
            retry <= 1'b1;
            state <= S_GAP;
          end else if (ph == S_DATA) begin
            retry <= 1'b0;
            state <= S_GAP;
            if (!is_unl) otp_done <= 1'b1;
            else if (byte_idx == 3'd5) begin
              unlock_done <= 1'b1;
              unlocked <= 1'b1;
            end
          end else state <= ph == S_DEV ? S_REG : S_DATA;
        end
        S_GAP: if (gap_cnt != 8'(GAP_CYCLES - 1)) gap_cnt <= gap_cnt + 8'd1;
        else if (retry && retry_cnt < 3'(MAX_RETRY)) begin
          retry_cnt <= retry_cnt + 3'd1;
          retry <= 1'b0;
          state <= S_DEV;
        end else if (retry) begin
          err <= 1'b1;
          err_code <= 2'b01;
          if (is_unl) unlocked <= 1'b0;
          state <= S_IDLE;
        end else if (is_unl && byte_idx != 3'd5) begin
          byte_idx <= byte_idx + 3'd1;
          retry_cnt <= '0;
          state <= S_DEV;
        end else state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_otp_sequencer.sv
// tb_i2c_otp_sequencer: directed bench acting as the I2C byte engine and both requesters.
module tb_i2c_otp_sequencer;
  logic clk = 0, rst = 1, unlock_req = 0, otp_req = 0, eng_ready = 1, eng_done = 0, eng_nack = 0;
  logic [47:0] passcode_in = 48'h50_48_53_47_4E_58;
  logic [7:0] otp_cmd = 8'h00;
  logic unlock_done, otp_done, err, unlocked, busy, eng_valid, eng_start, eng_stop;
  logic [1:0] err_code;
  logic [7:0] eng_byte;
  logic [7:0] pcb [6] = '{8'h50, 8'h48, 8'h53, 8'h47, 8'h4E, 8'h58};
  logic seen;
  int checks = 0, errors = 0, n;

  always #5 clk = ~clk;

  i2c_otp_sequencer dut (
    .clk(clk), .rst(rst), .unlock_req(unlock_req), .passcode_in(passcode_in),
    .otp_req(otp_req), .otp_cmd(otp_cmd), .unlock_done(unlock_done), .otp_done(otp_done),
    .err(err), .err_code(err_code), .unlocked(unlocked), .busy(busy),
    .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_start(eng_start), .eng_stop(eng_stop),
    .eng_byte(eng_byte), .eng_done(eng_done), .eng_nack(eng_nack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!eng_valid && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    chk("valid_timeout", cnt < 400, 1);
  endtask

  // one engine byte: wait for valid, check command, accept, then return done/nack
  task automatic serve(input string tag, input logic [7:0] b, input logic st, input logic sp,
                       input logic nk, input int exp_n);
    int c;
    wait_valid(c);
    if (exp_n >= 0) chk({tag, " gap"}, c, exp_n);
    chk({tag, " byte"}, eng_byte, b);
    chk({tag, " start"}, eng_start, st);
    chk({tag, " stop"}, eng_stop, sp);
    @(negedge clk);
    chk({tag, " valid_low"}, eng_valid, 0);
    eng_done = 1;
    eng_nack = nk;
    @(negedge clk);
    eng_done = 0;
    eng_nack = 0;
  endtask

  task automatic triple(input string tag, input logic [7:0] reg_a, input logic [7:0] data, input int exp_n);
    serve({tag, " dev"}, 8'h14, 1, 0, 0, exp_n);
    serve({tag, " reg"}, reg_a, 0, 0, 0, 0);
    serve({tag, " data"}, data, 0, 1, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    chk("rst valid", eng_valid, 0);
    chk("rst start_stop", {eng_start, eng_stop}, 0);
    chk("rst byte", eng_byte, 0);
    chk("rst unlocked_busy", {unlocked, busy}, 0);
    chk("rst pulses", {unlock_done, otp_done, err, err_code}, 0);
    rst = 0;
    // OTP while locked: rejected, no bus traffic, idle after the gap
    @(negedge clk);
    otp_req = 1;
    otp_cmd = 8'h11;
    @(negedge clk);
    chk("locked err", err, 1);
    chk("locked err_code", err_code, 2'b10);
    chk("locked busy", busy, 1);
    otp_req = 0;
    seen = eng_valid;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      seen |= eng_valid;
      if (k == 1) chk("locked err_pulse", err, 0);
      if (k == 15) chk("locked gap_busy", busy, 1);
      if (k == 16) chk("locked gap_idle", busy, 0);
    end
    chk("locked no_traffic", seen, 0);
    // simultaneous requests: unlock wins, with backpressure on first byte
    eng_ready = 0;
    otp_cmd = 8'h00;
    unlock_req = 1;
    otp_req = 1;
    wait_valid(n);
    chk("grant latency", n, 1);
    repeat (2) @(negedge clk);
    chk("hold valid", eng_valid, 1);
    chk("hold byte", eng_byte, 8'h14);
    chk("hold start", eng_start, 1);
    eng_ready = 1;
    for (int b = 0; b < 6; b++) begin
      triple("unl", 8'h05, pcb[b], b == 0 ? 0 : 16);
      if (b < 5) chk("unl early_done", unlock_done, 0);
    end
    chk("unl done", unlock_done, 1);
    chk("unl unlocked", unlocked, 1);
    chk("unl otp_done", otp_done, 0);
    unlock_req = 0;
    @(negedge clk);
    chk("unl done_pulse", unlock_done, 0);
    triple("otp", 8'h04, 8'h00, 16);
    chk("otp done", otp_done, 1);
    chk("otp err", err, 0);
    otp_req = 0;
    // NACK on REG of byte 3 twice, then ACK
    unlock_req = 1;
    for (int b = 0; b < 6; b++) begin
      if (b == 3) begin
        serve("nk dev1", 8'h14, 1, 0, 0, 16);
        serve("nk reg1", 8'h05, 0, 0, 1, 0);
        serve("nk dev2", 8'h14, 1, 0, 0, 16);
        serve("nk reg2", 8'h05, 0, 0, 1, 0);
      end
      triple("nk", 8'h05, pcb[b], b == 0 ? -1 : 16);
    end
    chk("nk done", unlock_done, 1);
    chk("nk err", err, 0);
    unlock_req = 0;
    @(negedge clk);
    // four NACKs on DEV: retries exhausted
    chk("ex pre_unlocked", unlocked, 1);
    unlock_req = 1;
    for (int a = 0; a < 4; a++) serve("ex dev", 8'h14, 1, 0, 1, a == 0 ? -1 : 16);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) chk("ex err_early", err, 0);
    end
    chk("ex err", err, 1);
    chk("ex err_code", err_code, 2'b01);
    chk("ex unlocked", unlocked, 0);
    chk("ex no_5th", eng_valid, 0);
    chk("ex idle", busy, 0);
    unlock_req = 0;
    // reset during WAIT of byte 2, then restart from byte 0
    @(negedge clk);
    unlock_req = 1;
    triple("rs", 8'h05, pcb[0], -1);
    triple("rs", 8'h05, pcb[1], 16);
    wait_valid(n);
    chk("rs b2_byte", eng_byte, 8'h14);
    @(negedge clk);
    chk("rs in_wait", {eng_valid, busy}, 2'b01);
    rst = 1;
    #1;
    chk("rs valid", eng_valid, 0);
    chk("rs busy", busy, 0);
    @(negedge clk);
    rst = 0;
    serve("rs restart_dev", 8'h14, 1, 0, 0, 1);
    serve("rs restart_reg", 8'h05, 0, 0, 0, 0);
    serve("rs restart_data", pcb[0], 0, 1, 0, 0);
    chk("rs unlocked", unlocked, 0);
    unlock_req = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_otp_sequencer.md
# i2c_otp_sequencer

Transaction sequencer sitting above the I2C byte engine in the OTP controller. Arbitrates between a passcode-unlock requester and an OTP-command requester and expands each request into register-write transactions: START + device address/W, register address, one data byte + STOP. Each write is retried on NACK and separated from the next by a bus-idle gap. Tracks the unlocked status that gates OTP commands.

## Interface
- DEV_ADDR, 7'h0A: 7-bit I2C slave address.
- REG_PASSCODE, 8'h05: passcode register address.
- REG_OTP, 8'h04: OTP read/write-enable register address.
- GAP_CYCLES, 16: idle cycles after every transaction; legal range 2..255.
- MAX_RETRY, 3: retries per transaction after the first NACK; legal range 0..7.
- clk  in  1  sequencer clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- unlock_req  in  1  level request to write the 6-byte passcode.
- passcode_in  in  48  passcode, captured on grant; byte 0 = [47:40] is sent first.
- otp_req  in  1  level request to write otp_cmd to REG_OTP.
- otp_cmd  in  8  OTP command (8'h00 read, 8'h11 write, 8'h01 none), captured on grant.
- unlock_done  out  1  one-cycle pulse: all 6 passcode bytes acknowledged.
- otp_done  out  1  one-cycle pulse: OTP command acknowledged.
- err  out  1  one-cycle pulse: request aborted.
- err_code  out  2  valid with err: 2'b01 retries exhausted, 2'b10 OTP rejected while locked.
- unlocked  out  1  set by unlock_done; cleared by reset or by any unlock err.
- busy  out  1  high in every state except IDLE.
- eng_valid  out  1  byte command valid to engine.
- eng_ready  in  1  engine accepts command when eng_valid && eng_ready.
- eng_start  out  1  qualifier: engine issues START before the byte.
- eng_stop  out  1  qualifier: engine issues STOP after the byte's ACK.
- eng_byte  out  8  byte to shift out MSB first.
- eng_done  in  1  one-cycle pulse: byte and ACK slot complete.
- eng_nack  in  1  valid with eng_done: slave NACKed. The engine then issues STOP on its own.

## Operation
- States: IDLE, DEV, REG, DATA, WAIT, GAP.
- IDLE:
  - With one request high, grant it.
  - With both high, round-robin against the last grant. After reset the last grant is OTP, so unlock wins first.
  - On grant, capture the payload, set byte_idx=0, retry_cnt=0, go to DEV.
  - otp_req granted while unlocked=0: pulse err with err_code=2'b10, go to GAP. No bus traffic.
- Per-state engine command:
  - DEV: eng_byte={DEV_ADDR,1'b0}, eng_start=1.
  - REG: eng_byte=REG_PASSCODE (unlock) or REG_OTP (OTP).
  - DATA: eng_byte=passcode byte[byte_idx] or otp_cmd, eng_stop=1.
  - Each of DEV/REG/DATA goes to WAIT on handshake.
- WAIT:
  - On eng_done with ACK: advance DEV->REG->DATA; after DATA, go to GAP.
  - On eng_done with NACK: go to GAP marked retry.
  - Every transaction, including each passcode byte, is a full DEV/REG/DATA triple.
- GAP: count GAP_CYCLES, then:
  - retry marked and retry_cnt<MAX_RETRY: increment retry_cnt, go to DEV with the same byte_idx.
  - retry marked and retry_cnt==MAX_RETRY: pulse err with 2'b01; for an unlock request, clear unlocked. Go to IDLE.
  - passcode byte_idx<5 acknowledged: byte_idx+1, retry_cnt=0, go to DEV.
  - otherwise: go to IDLE.
- unlock_done / otp_done pulse on GAP entry after the final acknowledged DATA byte. unlocked rises the same cycle as unlock_done.
- The requester drops its req within GAP_CYCLES-1 cycles of done/err. req levels are ignored outside IDLE.
- An unlock sequence is atomic: an OTP request waits until all 6 bytes finish or abort.

## Timing
- Reset values:
  - Outputs: eng_valid=0, eng_start=0, eng_stop=0, eng_byte=0, unlocked=0, busy=0, done/err=0, err_code=0.
  - Internal: state=IDLE, last grant=OTP.
- Grant to eng_valid: 1 cycle. Qualifiers are registered and stable while eng_valid is high.
- eng_valid stays high until the handshake, then is low the next cycle. At most one byte is in flight.
- eng_done while not in WAIT is ignored.
- GAP lasts exactly GAP_CYCLES cycles; IDLE re-arbitrates on the following cycle.
- Reset asserted mid-transaction: eng_valid drops immediately and all state clears. The engine shares rst.
- retry_cnt is 3 bits; with MAX_RETRY=0, the first NACK aborts.

## Test plan
- Unlock only, passcode 48'h50_48_53_47_4E_58, all ACK -> 6 triples: 8'h14, 8'h05, data bytes in order (one per triple). Gaps of 16 cycles between triples. One unlock_done, then unlocked=1.
- otp_req with otp_cmd=8'h11 while locked -> err with err_code=2'b10, no eng_valid, then IDLE after 16 cycles.
- unlock_req and otp_req (8'h00) asserted in the same cycle after reset -> unlock first. Once unlocked, OTP triple 8'h14, 8'h04, 8'h00, then otp_done.
- NACK on byte 3's REG phase twice, then ACK -> byte 3 triple repeated twice more, sequence completes, unlock_done.
- NACK 4 times on DEV with MAX_RETRY=3 -> err with err_code=2'b01, unlocked cleared, 4 DEV attempts total.
- rst pulsed while in WAIT of byte 2 -> eng_valid=0 and busy=0 immediately. After release, a new unlock_req restarts from byte 0.
